// File: rtl/psx_n64_btn_bridge_pkg.sv
// Shared definitions for the PSX-to-N64 button bridge: bit positions, poll FSM states
// and the PSX->N64 button map.
package psx_n64_btn_bridge_pkg;

    // PSX controller word bit positions (raw word is active-low)
    localparam int unsigned PSX_SEL   = 0;
    localparam int unsigned PSX_L3    = 1;
    localparam int unsigned PSX_R3    = 2;
    localparam int unsigned PSX_START = 3;
    localparam int unsigned PSX_DU    = 4;
    localparam int unsigned PSX_DR    = 5;
    localparam int unsigned PSX_DD    = 6;
    localparam int unsigned PSX_DL    = 7;
    localparam int unsigned PSX_L2    = 8;
    localparam int unsigned PSX_R2    = 9;
    localparam int unsigned PSX_L1    = 10;
    localparam int unsigned PSX_R1    = 11;
    localparam int unsigned PSX_TRI   = 12;
    localparam int unsigned PSX_O     = 13;
    localparam int unsigned PSX_X     = 14;
    localparam int unsigned PSX_SQ    = 15;

    // N64 response word bit positions (active-high)
    localparam int unsigned N64_CR    = 0;
    localparam int unsigned N64_CL    = 1;
    localparam int unsigned N64_CD    = 2;
    localparam int unsigned N64_CU    = 3;
    localparam int unsigned N64_R     = 4;
    localparam int unsigned N64_L     = 5;
    localparam int unsigned N64_RSVD  = 6;
    localparam int unsigned N64_RST   = 7;
    localparam int unsigned N64_DR    = 8;
    localparam int unsigned N64_DL    = 9;
    localparam int unsigned N64_DD    = 10;
    localparam int unsigned N64_DU    = 11;
    localparam int unsigned N64_START = 12;
    localparam int unsigned N64_Z     = 13;
    localparam int unsigned N64_B     = 14;
    localparam int unsigned N64_A     = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } poll_state_e;

    // Input is the PSX word already inverted to pressed=1; L3 has no N64 counterpart.
    function automatic logic [15:0] psx_to_n64(input logic [15:0] pressed);
        logic [15:0] n64;
        n64            = '0;
        n64[N64_A]     = pressed[PSX_X];
        n64[N64_B]     = pressed[PSX_O];
        n64[N64_Z]     = pressed[PSX_L2] | pressed[PSX_R2];
        n64[N64_START] = pressed[PSX_START];
        n64[N64_DU]    = pressed[PSX_DU];
        n64[N64_DD]    = pressed[PSX_DD];
        n64[N64_DL]    = pressed[PSX_DL];
        n64[N64_DR]    = pressed[PSX_DR];
        n64[N64_L]     = pressed[PSX_L1];
        n64[N64_R]     = pressed[PSX_R1];
        n64[N64_CU]    = pressed[PSX_TRI];
        n64[N64_CD]    = pressed[PSX_SEL];
        n64[N64_CL]    = pressed[PSX_SQ];
        n64[N64_CR]    = pressed[PSX_R3];
        return n64;
    endfunction

endpackage

// File: rtl/psx_n64_btn_bridge_if.sv
// Signal bundle between the bridge and its PSX poller / N64 responder neighbours.
// The master side is the bridge itself; the slave side is its environment.
interface psx_n64_btn_bridge_if;

    logic [15:0] psx_btns;
    logic        psx_frame_valid;
    logic        psx_poll_req;
    logic        n64_poll_start;
    logic        n64_poll_done;
    logic [15:0] n64_btns;
    logic        link_ok;

    modport master (
        input  psx_btns,
        input  psx_frame_valid,
        input  n64_poll_start,
        input  n64_poll_done,
        output psx_poll_req,
        output n64_btns,
        output link_ok
    );

    modport slave (
        output psx_btns,
        output psx_frame_valid,
        output n64_poll_start,
        output n64_poll_done,
        input  psx_poll_req,
        input  n64_btns,
        input  link_ok
    );

endinterface

// File: rtl/psx_n64_btn_bridge_btn_debounce.sv
// Per-bit frame debouncer: a bit flips only after FRAMES consecutive sampled frames
// disagree with its current debounced value.
module psx_n64_btn_bridge_btn_debounce #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned CW = $clog2(FRAMES + 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;

    always_comb begin
        dout_d = dout_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear) begin
                cnt_d[i]  = '0;
                dout_d[i] = 1'b0;
            end else if (sample_en) begin
                if (din[i] != dout_q[i]) begin
                    // FRAMES-th disagreeing frame flips the bit and restarts the count
                    if (cnt_q[i] == CW'(FRAMES - 1)) begin
                        dout_d[i] = din[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '{default: '0};
            dout_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/psx_n64_btn_bridge.sv
// PSX-to-N64 button bridge: schedules PSX polls, debounces frames, tracks link health
// and holds the N64 button word steady while the console is mid-poll.
module psx_n64_btn_bridge
    import psx_n64_btn_bridge_pkg::*;
#(
    parameter int unsigned POLL_PERIOD     = 50000,
    parameter int unsigned FRAME_TIMEOUT   = 4096,
    parameter int unsigned STALE_LIMIT     = 3,
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned N64_POLL_MAX    = 8192
) (
    input logic                  clk,
    input logic                  rst_n,
    psx_n64_btn_bridge_if.master bridge_if
);

    localparam int unsigned PW = $clog2(POLL_PERIOD + 1);
    localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(STALE_LIMIT + 1);
    localparam int unsigned WW = $clog2(N64_POLL_MAX + 1);

    poll_state_e state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [SW-1:0] stale_q, stale_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          link_ok_q, link_ok_d;
    logic [15:0]   frame_q, frame_d;
    logic          frame_acc_q, frame_acc_d;
    logic          freeze_q, freeze_d;
    logic          pending_q, pending_d;
    logic [15:0]   n64_btns_q, n64_btns_d;
    logic          deb_clear;
    logic          wd_hit;
    logic [15:0]   deb_btns;
    logic [15:0]   mapped;

    // Poll scheduling, frame acceptance and stale-link tracking
    always_comb begin
        state_d     = state_q;
        period_d    = '0;
        tout_d      = '0;
        stale_d     = stale_q;
        link_ok_d   = link_ok_q;
        frame_d     = frame_q;
        frame_acc_d = 1'b0;
        deb_clear   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (period_q == PW'(POLL_PERIOD - 1) || bridge_if.n64_poll_done) begin
                    state_d = S_REQ;
                end else begin
                    period_d = period_q + 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bridge_if.psx_frame_valid) begin
                    frame_d     = ~bridge_if.psx_btns;
                    frame_acc_d = 1'b1;
                    stale_d     = '0;
                    link_ok_d   = 1'b1;
                    state_d     = S_IDLE;
                end else if (tout_q == TW'(FRAME_TIMEOUT - 1)) begin
                    stale_d = (stale_q == SW'(STALE_LIMIT)) ? stale_q : stale_q + 1'b1;
                    // Dead link: report released and make later frames re-qualify
                    if (stale_d == SW'(STALE_LIMIT)) begin
                        link_ok_d = 1'b0;
                        deb_clear = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    psx_n64_btn_bridge_btn_debounce #(
        .WIDTH  (16),
        .FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (frame_acc_q),
        .clear     (deb_clear),
        .din       (frame_q),
        .dout      (deb_btns)
    );

    assign mapped = psx_to_n64(deb_btns);
    assign wd_hit = freeze_q && (wd_q == WW'(N64_POLL_MAX - 1));

    // Freeze: done beats start, start beats a same-cycle word update
    always_comb begin
        freeze_d = freeze_q;
        wd_d     = '0;
        if (bridge_if.n64_poll_done) begin
            freeze_d = 1'b0;
        end else if (bridge_if.n64_poll_start) begin
            freeze_d = 1'b1;
        end else if (wd_hit) begin
            freeze_d = 1'b0;
        end
        if (freeze_d && freeze_q && !bridge_if.n64_poll_start) begin
            wd_d = (wd_q == WW'(N64_POLL_MAX)) ? wd_q : wd_q + 1'b1;
        end

        if (freeze_d) begin
            n64_btns_d = n64_btns_q;
            pending_d  = pending_q | (mapped != n64_btns_q);
        end else begin
            n64_btns_d = mapped;
            pending_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            period_q    <= '0;
            tout_q      <= '0;
            stale_q     <= '0;
            wd_q        <= '0;
            link_ok_q   <= 1'b0;
            frame_q     <= '0;
            frame_acc_q <= 1'b0;
            freeze_q    <= 1'b0;
            pending_q   <= 1'b0;
            n64_btns_q  <= '0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            tout_q      <= tout_d;
            stale_q     <= stale_d;
            wd_q        <= wd_d;
            link_ok_q   <= link_ok_d;
            frame_q     <= frame_d;
            frame_acc_q <= frame_acc_d;
            freeze_q    <= freeze_d;
            pending_q   <= pending_d;
            n64_btns_q  <= n64_btns_d;
        end
    end

    assign bridge_if.psx_poll_req = (state_q == S_REQ);
    assign bridge_if.n64_btns     = n64_btns_q;
    assign bridge_if.link_ok      = link_ok_q;

endmodule

// File: tb/tb_psx_n64_btn_bridge.sv
// Directed bench for psx_n64_btn_bridge with shortened timing parameters.
module tb_psx_n64_btn_bridge;

    localparam int unsigned P = 64;
    localparam int unsigned T = 32;
    localparam int unsigned S = 3;
    localparam int unsigned D = 2;
    localparam int unsigned W = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   s_cyc = 0;

    always #5 clk = ~clk;

    psx_n64_btn_bridge_if bus ();

    psx_n64_btn_bridge #(
        .POLL_PERIOD     (P),
        .FRAME_TIMEOUT   (T),
        .STALE_LIMIT     (S),
        .DEBOUNCE_FRAMES (D),
        .N64_POLL_MAX    (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bridge_if (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.psx_poll_req !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check1("req_seen", bus.psx_poll_req, 1'b1);
    endtask

    // Entered just after the edge that put the FSM in S_REQ
    task automatic send_frame(input logic [15:0] btns);
        tick();
        check1("req_pulse", bus.psx_poll_req, 1'b0);
        bus.psx_btns        = btns;
        bus.psx_frame_valid = 1'b1;
        tick();
        bus.psx_frame_valid = 1'b0;
        bus.psx_btns        = 16'hFFFF;
    endtask

    task automatic poll_frame(input logic [15:0] btns);
        wait_req();
        send_frame(btns);
    endtask

    task automatic check_first_req();
        repeat (P - 1) tick();
        check1("req_early", bus.psx_poll_req, 1'b0);
        tick();
        check1("req_first", bus.psx_poll_req, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.psx_btns        = 16'hFFFF;
        bus.psx_frame_valid = 1'b0;
        bus.n64_poll_start  = 1'b0;
        bus.n64_poll_done   = 1'b0;
        rst_n               = 1'b0;
        repeat (3) tick();
        check16("rst_btns", bus.n64_btns, 16'h0000);
        check1("rst_link", bus.link_ok, 1'b0);
        check1("rst_req", bus.psx_poll_req, 1'b0);
        rst_n = 1'b1;
        check_first_req();

        // Debounce: X pressed needs two agreeing frames
        send_frame(16'hBFFF);
        check1("link_up", bus.link_ok, 1'b1);
        tick();
        tick();
        check16("deb_one_frame", bus.n64_btns, 16'h0000);
        poll_frame(16'hBFFF);
        tick();
        check16("lat_t1", bus.n64_btns, 16'h0000);
        tick();
        check16("x_pressed", bus.n64_btns, 16'h8000);
        poll_frame(16'hFFFF);
        tick();
        tick();
        check16("glitch_hold", bus.n64_btns, 16'h8000);
        poll_frame(16'hBFFF);
        tick();
        tick();
        check16("glitch_reset", bus.n64_btns, 16'h8000);

        // Freeze across the frame that completes O pressed / X released
        poll_frame(16'hDFFF);
        bus.n64_poll_start = 1'b1;
        tick();
        bus.n64_poll_start = 1'b0;
        poll_frame(16'hDFFF);
        tick();
        tick();
        check16("freeze_hold", bus.n64_btns, 16'h8000);
        bus.n64_poll_done = 1'b1;
        tick();
        bus.n64_poll_done = 1'b0;
        check16("freeze_release", bus.n64_btns, 16'h4000);
        check1("prefetch_req", bus.psx_poll_req, 1'b1);
        send_frame(16'hDFFF);

        // Start in the same cycle as a word update
        poll_frame(16'hFFFF);
        poll_frame(16'hFFFF);
        tick();
        bus.n64_poll_start = 1'b1;
        tick();
        bus.n64_poll_start = 1'b0;
        check16("collide_hold", bus.n64_btns, 16'h4000);
        repeat (3) tick();
        check16("collide_frozen", bus.n64_btns, 16'h4000);
        bus.n64_poll_done = 1'b1;
        tick();
        bus.n64_poll_done = 1'b0;
        check16("collide_release", bus.n64_btns, 16'h0000);
        send_frame(16'hFFFF);

        // Start and done together leave the word unfrozen
        bus.n64_poll_start = 1'b1;
        bus.n64_poll_done  = 1'b1;
        tick();
        bus.n64_poll_start = 1'b0;
        bus.n64_poll_done  = 1'b0;
        check1("both_prefetch", bus.psx_poll_req, 1'b1);
        send_frame(16'hBFFF);
        poll_frame(16'hBFFF);
        tick();
        tick();
        check16("both_unfrozen", bus.n64_btns, 16'h8000);

        // Watchdog releases a freeze with no done
        poll_frame(16'hDFFF);
        bus.n64_poll_start = 1'b1;
        tick();
        s_cyc = cyc;
        bus.n64_poll_start = 1'b0;
        poll_frame(16'hDFFF);
        tick();
        tick();
        check16("wd_hold", bus.n64_btns, 16'h8000);
        while (cyc < s_cyc + int'(W) - 1) tick();
        check16("wd_before", bus.n64_btns, 16'h8000);
        tick();
        check16("wd_release", bus.n64_btns, 16'h4000);

        // Stale link: three consecutive timeouts
        for (int i = 0; i < 2; i++) begin
            wait_req();
            repeat (T) tick();
            check1("stale_link_hold", bus.link_ok, 1'b1);
            tick();
        end
        wait_req();
        repeat (T) tick();
        check1("stale_link_last", bus.link_ok, 1'b1);
        tick();
        check1("stale_link_down", bus.link_ok, 1'b0);
        check16("stale_btn_lag", bus.n64_btns, 16'h4000);
        tick();
        check16("stale_btn_clear", bus.n64_btns, 16'h0000);

        // Frames outside S_WAIT are ignored
        bus.psx_btns        = 16'hBFFF;
        bus.psx_frame_valid = 1'b1;
        tick();
        bus.psx_frame_valid = 1'b0;
        tick();
        bus.psx_frame_valid = 1'b1;
        tick();
        bus.psx_frame_valid = 1'b0;
        bus.psx_btns        = 16'hFFFF;
        repeat (3) tick();
        check1("ignore_link", bus.link_ok, 1'b0);
        check16("ignore_btns", bus.n64_btns, 16'h0000);

        // Reset asserted while waiting for a frame
        poll_frame(16'hBFFF);
        poll_frame(16'hBFFF);
        tick();
        tick();
        check16("pre_rst_btns", bus.n64_btns, 16'h8000);
        check1("pre_rst_link", bus.link_ok, 1'b1);
        wait_req();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check16("mid_rst_btns", bus.n64_btns, 16'h0000);
        check1("mid_rst_link", bus.link_ok, 1'b0);
        check1("mid_rst_req", bus.psx_poll_req, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        check_first_req();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
